// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit that owns the HI/LO pair. It produces one
// quotient or product bit per clock, and results land after WIDTH+1 cycles.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] data_1,
  input  logic [WIDTH-1:0] data_2,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state_reg, state_next;
  logic [CW-1:0]      cnt_reg;
  logic [2*WIDTH-1:0] acc_reg, acc_next;
  logic [WIDTH-1:0]   opnd_reg;
  logic               is_div_reg, neg_q_reg, neg_r_reg, dz_reg;
  logic [WIDTH-1:0]   hi_reg, lo_reg;
  logic               busy_reg, done_reg, dz_out_reg;

  logic               sign_1, sign_2;
  logic [WIDTH-1:0]   mag_1, mag_2;
  logic [WIDTH:0]     mul_sum, rem_sh, diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo, rem, hi_res, lo_res;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (cnt_reg == LAST) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Signed ops run on magnitudes; the signs are reapplied in FIX.
  always_comb begin
    sign_1 = ~op[0] & data_1[WIDTH-1];
    sign_2 = ~op[0] & data_2[WIDTH-1];
    mag_1  = sign_1 ? -data_1 : data_1;
    mag_2  = sign_2 ? -data_2 : data_2;
  end

  // Multiply keeps the multiplier in the low half and shifts right; divide
  // shifts the dividend left into the remainder half and collects quotient bits.
  always_comb begin
    mul_sum = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + {1'b0, (acc_reg[0] ? opnd_reg : '0)};
    rem_sh  = acc_reg[2*WIDTH-1:WIDTH-1];
    diff    = rem_sh - {1'b0, opnd_reg};
    if (!is_div_reg)
      acc_next = {mul_sum, acc_reg[WIDTH-1:1]};
    else if (diff[WIDTH])
      acc_next = {rem_sh[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0};
    else
      acc_next = {diff[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1};
  end

  // A zero divisor leaves the dividend magnitude as remainder, so the sign fix
  // restores the original dividend into HI; only LO needs forcing.
  always_comb begin
    prod_fix = neg_q_reg ? -acc_reg : acc_reg;
    quo      = acc_reg[WIDTH-1:0];
    rem      = acc_reg[2*WIDTH-1:WIDTH];
    if (is_div_reg) begin
      lo_res = dz_reg ? '1 : (neg_q_reg ? -quo : quo);
      hi_res = neg_r_reg ? -rem : rem;
    end else begin
      lo_res = prod_fix[WIDTH-1:0];
      hi_res = prod_fix[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg    <= '0;
      acc_reg    <= '0;
      opnd_reg   <= '0;
      is_div_reg <= 1'b0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      dz_reg     <= 1'b0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      dz_out_reg <= 1'b0;
    end else begin
      done_reg   <= 1'b0;
      dz_out_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            cnt_reg    <= '0;
            busy_reg   <= 1'b1;
            is_div_reg <= op[1];
            neg_q_reg  <= sign_1 ^ sign_2;
            neg_r_reg  <= sign_1;
            dz_reg     <= op[1] && (data_2 == '0);
            acc_reg    <= op[1] ? {{WIDTH{1'b0}}, mag_1} : {{WIDTH{1'b0}}, mag_2};
            opnd_reg   <= op[1] ? mag_2 : mag_1;
          end else begin
            if (mthi) hi_reg <= wr_data;
            if (mtlo) lo_reg <= wr_data;
          end
        end
        RUN: begin
          acc_reg <= acc_next;
          cnt_reg <= cnt_reg + 1'b1;
        end
        FIX: begin
          hi_reg     <= hi_res;
          lo_reg     <= lo_res;
          busy_reg   <= 1'b0;
          done_reg   <= 1'b1;
          dz_out_reg <= dz_reg;
        end
        default: ;
      endcase
    end
  end

  assign hi          = hi_reg;
  assign lo          = lo_reg;
  assign busy        = busy_reg;
  assign done        = done_reg;
  assign div_by_zero = dz_out_reg;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: arithmetic reference model feeds a queue
// that a monitor drains on every done pulse.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op_i = 2'd0;
  logic [31:0] d1 = '0, d2 = '0, wr_data = '0;
  logic        mthi = 1'b0, mtlo = 1'b0;
  logic [31:0] hi, lo;
  logic        busy, done, div_by_zero;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   chk_cnt = 0;
  int   pass_cnt = 0;
  int   done_cnt = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op_i),
    .data_1(d1), .data_2(d2), .mthi(mthi), .mtlo(mtlo), .wr_data(wr_data),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    chk_cnt++;
    if (act === expv) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, expv);
  endtask

  function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [63:0] p;
    int          sa, sb;
    e = '0;
    sa = a;
    sb = b;
    case (o)
      2'd0: begin p = longint'(sa) * longint'(sb); e.hi = p[63:32]; e.lo = p[31:0]; end
      2'd1: begin p = {32'h0, a} * {32'h0, b};     e.hi = p[63:32]; e.lo = p[31:0]; end
      2'd2: begin
        if (b == 0) begin e.lo = 32'hFFFFFFFF; e.hi = a; e.dz = 1'b1; end
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin e.lo = 32'h80000000; e.hi = 0; end
        else begin e.lo = sa / sb; e.hi = sa % sb; end
      end
      default: begin
        if (b == 0) begin e.lo = 32'hFFFFFFFF; e.hi = a; e.dz = 1'b1; end
        else begin e.lo = a / b; e.hi = a % b; end
      end
    endcase
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        chk_cnt++;
        $display("FAIL unexpected_done: done with no outstanding op, hi=%h lo=%h", hi, lo);
      end else begin
        mon_e = exp_q.pop_front();
        check("result_hi", {32'h0, hi}, {32'h0, mon_e.hi});
        check("result_lo", {32'h0, lo}, {32'h0, mon_e.lo});
        check("result_dz", {63'h0, div_by_zero}, {63'h0, mon_e.dz});
      end
    end
  end

  // Called at a negedge with the unit idle; returns one negedge after the accept edge.
  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op_i = o; d1 = a; d2 = b; start = 1'b1;
    exp_q.push_back(model(o, a, b));
    $display("op=%0d a=%h b=%h issued", o, a, b);
    @(negedge clk);
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    op_i = 2'($urandom); d1 = $urandom; d2 = $urandom;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && busy; i++) @(negedge clk);
    if (busy) begin
      chk_cnt++;
      $display("FAIL wait_idle: busy still %b after 100 cycles, required 0", busy);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_hi"}, {32'h0, hi}, 64'h0);
    check({tag, "_lo"}, {32'h0, lo}, 64'h0);
    check({tag, "_busy"}, {63'h0, busy}, 64'h0);
    check({tag, "_done"}, {63'h0, done}, 64'h0);
    check({tag, "_dz"}, {63'h0, div_by_zero}, 64'h0);
  endtask

  initial begin
    int          n, dc;
    logic        held;
    logic [1:0]  o;
    logic [31:0] a, b;

    @(negedge clk);
    check_zero_outputs("reset");
    reset = 1'b0;
    @(negedge clk);

    mthi = 1'b1; wr_data = 32'hAAAA0000;
    @(negedge clk);
    mthi = 1'b0;
    check("mthi_hi", {32'h0, hi}, 64'hAAAA0000);
    check("mthi_lo", {32'h0, lo}, 64'h0);
    mtlo = 1'b1; wr_data = 32'h00005555;
    @(negedge clk);
    mtlo = 1'b0;
    check("mtlo_lo", {32'h0, lo}, 64'h5555);
    check("mtlo_hi", {32'h0, hi}, 64'hAAAA0000);

    // MULTU with an mthi in the accept cycle that must be dropped; HI/LO hold throughout.
    mthi = 1'b1; wr_data = 32'h11111111;
    launch(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    held = 1'b1; n = 0;
    while (busy && n < 100) begin
      if (hi !== 32'hAAAA0000 || lo !== 32'h00005555) held = 1'b0;
      n++;
      @(negedge clk);
    end
    check("busy_cycles", 64'(n), 64'd33);
    check("done_after_busy", {63'h0, done}, 64'h1);
    check("hold_during_op", {63'h0, held}, 64'h1);

    // MULT -3*7, with a second start and an mtlo while busy.
    @(negedge clk);
    launch(2'd0, 32'hFFFFFFFD, 32'h00000007);
    repeat (5) @(negedge clk);
    start = 1'b1; op_i = 2'd3; d1 = 32'd9; d2 = 32'd3; mtlo = 1'b1; wr_data = 32'hDEAD;
    @(negedge clk);
    start = 1'b0; mtlo = 1'b0;
    check("mtlo_busy_ignored", {32'h0, lo}, 64'h1);
    wait_idle();
    @(negedge clk);
    dc = done_cnt;
    repeat (40) @(negedge clk);
    check("no_queued_start", 64'(done_cnt), 64'(dc));

    launch(2'd2, 32'hFFFFFFF9, 32'h00000002); wait_idle(); @(negedge clk);
    launch(2'd2, 32'h80000000, 32'hFFFFFFFF); wait_idle(); @(negedge clk);
    launch(2'd3, 32'h00001234, 32'h00000000); wait_idle(); @(negedge clk);

    // Reset at RUN cycle 10 aborts the operation.
    launch(2'd2, 32'd100, 32'd7);
    repeat (10) @(negedge clk);
    dc = done_cnt;
    reset = 1'b1;
    #1;
    check_zero_outputs("mid_reset");
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    check("no_done_after_abort", 64'(done_cnt), 64'(dc));
    check("idle_after_abort", {63'h0, busy}, 64'h0);

    // Back-to-back: new start issued in the done cycle.
    launch(2'd1, $urandom, $urandom);
    for (int i = 0; i < 100 && !done; i++) @(negedge clk);
    check("b2b_first_done", {63'h0, done}, 64'h1);
    launch(2'd3, 32'd1000, 32'd7);
    check("b2b_accepted", {63'h0, busy}, 64'h1);
    wait_idle();
    @(negedge clk);

    for (int k = 0; k < 40; k++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: b = $urandom_range(1, 15);
        3: a = $urandom_range(0, 255);
        default: ;
      endcase
      launch(o, a, b);
      wait_idle();
      @(negedge clk);
    end

    repeat (3) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", pass_cnt, chk_cnt);
    $fatal(1, "watchdog");
  end

endmodule
